// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
package sseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/BCDtoSSeg.sv
// Hex nibble to active-low segments a..g (index 0 = a).
module BCDtoSSeg
    import sseg_pkg::*;
(
    input  logic [3:0] BCD,
    output logic [0:6] SSeg
);

    always_comb begin
        SSeg = SEG_BLANK;
        case (BCD)
            4'h0: SSeg = 7'b0000001;
            4'h1: SSeg = 7'b1001111;
            4'h2: SSeg = 7'b0010010;
            4'h3: SSeg = 7'b0000110;
            4'h4: SSeg = 7'b1001100;
            4'h5: SSeg = 7'b0100100;
            4'h6: SSeg = 7'b0100000;
            4'h7: SSeg = 7'b0001111;
            4'h8: SSeg = 7'b0000000;
            4'h9: SSeg = 7'b0000100;
            4'hA: SSeg = 7'b0001000;
            4'hB: SSeg = 7'b1100000;
            4'hC: SSeg = 7'b0110001;
            4'hD: SSeg = 7'b1000010;
            4'hE: SSeg = 7'b0110000;
            4'hF: SSeg = 7'b0111000;
            default: SSeg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sseg_ndisplay.sv
// N-digit multiplexed seven-segment scanner with guard blanking,
// decimal points, leading-zero blanking and a per-frame shadow copy.
module sseg_ndisplay
    import sseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 100000,
    parameter int GUARD    = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   num,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    lzb,
    output logic [0:6]              SSeg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_start
);

    localparam int IW = clog2(N_DIGITS);
    localparam int CW = clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   num_sh_q;
    logic [N_DIGITS-1:0]     dp_sh_q;
    logic                    lzb_sh_q;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic [0:6]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fs_q;

    logic                    frame_edge;
    logic                    cnt_wrap;
    slot_state_t             state;
    logic                    hz;
    logic [N_DIGITS-1:0]     blank;
    logic [3:0]              digit;
    logic                    dp_sel;
    logic                    blank_sel;
    logic                    show;
    logic [0:6]              dec_seg;

    // cnt_q/idx_q describe the slot position being entered on this edge.
    assign frame_edge = (cnt_q == '0) && (idx_q == '0);
    assign cnt_wrap   = (cnt_q == CNT_LAST);
    assign state      = (cnt_q >= GUARD_C) ? ST_SHOW : ST_GUARD;

    always_comb begin
        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // A digit is blanked when it and all digits above it are zero.
    always_comb begin
        hz    = 1'b1;
        blank = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            hz = hz && (num_sh_q[4*i +: 4] == 4'd0);
            if (i != 0) blank[i] = lzb_sh_q && hz;
        end
    end

    always_comb begin
        digit     = 4'd0;
        dp_sel    = 1'b0;
        blank_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (IW'(i) == idx_q) begin
                digit     = num_sh_q[4*i +: 4];
                dp_sel    = dp_sh_q[i];
                blank_sel = blank[i];
            end
        end
    end

    BCDtoSSeg u_dec (
        .BCD  (digit),
        .SSeg (dec_seg)
    );

    always_comb begin
        show = (state == ST_SHOW) && !blank_sel;
        for (int i = 0; i < N_DIGITS; i++) begin
            an_d[i] = !(show && (IW'(i) == idx_q));
        end
        seg_d = show ? dec_seg : SEG_BLANK;
        dp_d  = show ? ~dp_sel : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            num_sh_q <= '0;
            dp_sh_q  <= '0;
            lzb_sh_q <= 1'b0;
            an_q     <= '1;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            fs_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            if (frame_edge) begin
                num_sh_q <= num;
                dp_sh_q  <= dp_in;
                lzb_sh_q <= lzb;
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fs_q  <= frame_edge;
        end
    end

    assign an          = an_q;
    assign SSeg        = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sseg_ndisplay.sv
// Directed bench for sseg_ndisplay (N=4 and N=1, DIV=8, GUARD=2).
module tb_sseg_ndisplay;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] num = 16'h1234;
    logic [3:0]  dp_in = 4'b0000;
    logic        lzb = 1'b0;
    logic [0:6]  sseg4;
    logic        dp4;
    logic [3:0]  an4;
    logic        fs4;

    logic        rst1 = 1'b1;
    logic [3:0]  num1 = 4'hF;
    logic [0:0]  dp_in1 = 1'b0;
    logic [0:6]  sseg1;
    logic        dp1;
    logic [0:0]  an1;
    logic        fs1;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] t_an [4];
    logic [0:6] t_seg [4];
    logic       t_dp [4];

    always #5 clk = ~clk;

    sseg_ndisplay #(.N_DIGITS(4), .DIV(8), .GUARD(2)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .num         (num),
        .dp_in       (dp_in),
        .lzb         (lzb),
        .SSeg        (sseg4),
        .dp          (dp4),
        .an          (an4),
        .frame_start (fs4)
    );

    sseg_ndisplay #(.N_DIGITS(1), .DIV(8), .GUARD(2)) dut1 (
        .clk         (clk),
        .rst         (rst1),
        .num         (num1),
        .dp_in       (dp_in1),
        .lzb         (1'b0),
        .SSeg        (sseg1),
        .dp          (dp1),
        .an          (an1),
        .frame_start (fs1)
    );

    function automatic logic [0:6] hexseg(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [3:0] a,
                            input logic [0:6] sg, input logic d);
        t_an[s]  = a;
        t_seg[s] = sg;
        t_dp[s]  = d;
    endtask

    task automatic set_basic();
        set_slot(0, 4'b1110, hexseg(4'h4), 1'b1);
        set_slot(1, 4'b1101, hexseg(4'h3), 1'b1);
        set_slot(2, 4'b1011, hexseg(4'h2), 1'b1);
        set_slot(3, 4'b0111, hexseg(4'h1), 1'b1);
    endtask

    task automatic expect_at(input int e, output logic [3:0] ea,
                             output logic [0:6] es, output logic ed,
                             output logic ef);
        int s;
        int k;
        s  = (e / 8) % 4;
        k  = e % 8;
        ea = (k >= 2) ? t_an[s] : 4'hF;
        es = (k >= 2) ? t_seg[s] : 7'h7F;
        ed = (k >= 2) ? t_dp[s] : 1'b1;
        ef = (s == 0) && (k == 0);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        rst1 = 1'b1;
        repeat (3) step();
        n_cmp++;
        if ({an4, sseg4, dp4, fs4} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset4 an=%b seg=%b dp=%b fs=%b req 1111/1111111/1/0",
                     an4, sseg4, dp4, fs4);
        end
        n_cmp++;
        if ({an1, sseg1, dp1, fs1} !== {1'b1, 7'h7F, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset1 an=%b seg=%b dp=%b fs=%b req 1/1111111/1/0",
                     an1, sseg1, dp1, fs1);
        end
    endtask

    task automatic test_basic();
        logic [3:0] ea;
        logic [0:6] es;
        logic       ed, ef;
        num   = 16'h1234;
        lzb   = 1'b0;
        dp_in = 4'b0000;
        set_basic();
        rst = 1'b0;
        for (int e = 0; e < 64; e++) begin
            step();
            expect_at(e, ea, es, ed, ef);
            n_cmp++;
            if ({an4, sseg4, dp4, fs4} !== {ea, es, ed, ef}) begin
                n_err++;
                $display("FAIL basic e=%0d got %b/%b/%b/%b req %b/%b/%b/%b",
                         e, an4, sseg4, dp4, fs4, ea, es, ed, ef);
            end
        end
    endtask

    task automatic test_lzb();
        logic [3:0] ea;
        logic [0:6] es;
        logic       ed, ef;
        for (int f = 0; f < 3; f++) begin
            case (f)
                0: begin
                    num = 16'h0050; lzb = 1'b1;
                    set_slot(0, 4'b1110, hexseg(4'h0), 1'b1);
                    set_slot(1, 4'b1101, hexseg(4'h5), 1'b1);
                    set_slot(2, 4'b1111, 7'h7F, 1'b1);
                    set_slot(3, 4'b1111, 7'h7F, 1'b1);
                end
                1: begin
                    num = 16'h0000; lzb = 1'b1;
                    set_slot(0, 4'b1110, hexseg(4'h0), 1'b1);
                    set_slot(1, 4'b1111, 7'h7F, 1'b1);
                end
                default: begin
                    num = 16'h0000; lzb = 1'b0;
                    set_slot(0, 4'b1110, hexseg(4'h0), 1'b1);
                    set_slot(1, 4'b1101, hexseg(4'h0), 1'b1);
                    set_slot(2, 4'b1011, hexseg(4'h0), 1'b1);
                    set_slot(3, 4'b0111, hexseg(4'h0), 1'b1);
                end
            endcase
            for (int e = 0; e < 32; e++) begin
                step();
                expect_at(e, ea, es, ed, ef);
                n_cmp++;
                if ({an4, sseg4, dp4, fs4} !== {ea, es, ed, ef}) begin
                    n_err++;
                    $display("FAIL lzb f=%0d e=%0d got %b/%b/%b/%b req %b/%b/%b/%b",
                             f, e, an4, sseg4, dp4, fs4, ea, es, ed, ef);
                end
            end
        end
    endtask

    task automatic test_coherence();
        logic [3:0] ea;
        logic [0:6] es;
        logic       ed, ef;
        num = 16'h1234;
        lzb = 1'b0;
        set_basic();
        for (int e = 0; e < 64; e++) begin
            if (e == 32) begin
                set_slot(0, 4'b1110, hexseg(4'hD), 1'b1);
                set_slot(1, 4'b1101, hexseg(4'hC), 1'b1);
                set_slot(2, 4'b1011, hexseg(4'hB), 1'b1);
                set_slot(3, 4'b0111, hexseg(4'hA), 1'b1);
            end
            step();
            expect_at(e, ea, es, ed, ef);
            n_cmp++;
            if ({an4, sseg4, dp4, fs4} !== {ea, es, ed, ef}) begin
                n_err++;
                $display("FAIL coherence e=%0d got %b/%b/%b/%b req %b/%b/%b/%b",
                         e, an4, sseg4, dp4, fs4, ea, es, ed, ef);
            end
            if (e == 10) num = 16'hABCD;
        end
    endtask

    task automatic test_dp();
        logic [3:0] ea;
        logic [0:6] es;
        logic       ed, ef;
        num   = 16'h1234;
        dp_in = 4'b0100;
        set_basic();
        t_dp[2] = 1'b0;
        for (int e = 0; e < 32; e++) begin
            step();
            expect_at(e, ea, es, ed, ef);
            n_cmp++;
            if ({an4, sseg4, dp4, fs4} !== {ea, es, ed, ef}) begin
                n_err++;
                $display("FAIL dp e=%0d got %b/%b/%b/%b req %b/%b/%b/%b",
                         e, an4, sseg4, dp4, fs4, ea, es, ed, ef);
            end
        end
        dp_in = 4'b0000;
    endtask

    task automatic test_reset_midslot();
        logic [3:0] ea;
        logic [0:6] es;
        logic       ed, ef;
        set_basic();
        for (int e = 0; e < 19; e++) step();
        n_cmp++;
        if (an4 !== 4'b1011) begin
            n_err++;
            $display("FAIL midslot_pre an=%b req 1011", an4);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({an4, sseg4, dp4, fs4} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL midslot_rst got %b/%b/%b/%b req 1111/1111111/1/0",
                     an4, sseg4, dp4, fs4);
        end
        rst = 1'b0;
        for (int e = 0; e < 32; e++) begin
            step();
            expect_at(e, ea, es, ed, ef);
            n_cmp++;
            if ({an4, sseg4, dp4, fs4} !== {ea, es, ed, ef}) begin
                n_err++;
                $display("FAIL restart e=%0d got %b/%b/%b/%b req %b/%b/%b/%b",
                         e, an4, sseg4, dp4, fs4, ea, es, ed, ef);
            end
        end
    endtask

    task automatic test_single();
        logic       ea;
        logic [0:6] es;
        logic       ef;
        int         k;
        rst1 = 1'b0;
        for (int e = 0; e < 24; e++) begin
            step();
            k  = e % 8;
            ea = (k < 2);
            es = (k >= 2) ? hexseg(4'hF) : 7'h7F;
            ef = (k == 0);
            n_cmp++;
            if ({an1, sseg1, dp1, fs1} !== {ea, es, 1'b1, ef}) begin
                n_err++;
                $display("FAIL single e=%0d got %b/%b/%b/%b req %b/%b/1/%b",
                         e, an1, sseg1, dp1, fs1, ea, es, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lzb();
        test_coherence();
        test_dp();
        test_reset_midslot();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
